// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-enable divider, h/v pixel counters and registered
// sync, active-video and line/frame start decode aligned to the counter updates.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] h_next_p0;
    logic [CNT_W-1:0] v_next_p0;
    logic             h_wrap_p0;
    logic             v_wrap_p0;

    // Stage p0: next-state counts; decode below uses these so outputs move with the counters
    always_comb begin
        h_next_p0 = h_count;
        v_next_p0 = v_count;
        h_wrap_p0 = pix_en && (h_count == H_LAST);
        v_wrap_p0 = h_wrap_p0 && (v_count == V_LAST);
        if (pix_en) begin
            if (h_wrap_p0) begin
                h_next_p0 = '0;
                v_next_p0 = v_wrap_p0 ? '0 : v_count + 1'b1;
            end else begin
                h_next_p0 = h_count + 1'b1;
            end
        end
    end

    // Stage p1: registered counters and decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= (div == DIV_LAST) ? '0 : div + 1'b1;
            pix_en      <= (div == DIV_LAST);
            h_count     <= h_next_p0;
            v_count     <= v_next_p0;
            h_sync      <= sync_level(in_window(h_next_p0, HS_START, HS_END));
            v_sync      <= sync_level(in_window(v_next_p0, VS_START, VS_END));
            video_on    <= (h_next_p0 < H_ACT) && (v_next_p0 < V_ACT);
            // Strobes follow the one-clk pix_en, so they stay one clk wide for any divider
            line_start  <= h_wrap_p0;
            frame_start <= v_wrap_p0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: three configurations are checked
// every clock against an arithmetic model of elapsed pixel time since reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_edge = 0;     // edges since the last reset edge
    bit in_rst = 1'b1;  // last edge sampled rst=1

    // Instance a: tiny frame, CLK_DIV=3, active-high sync
    logic       a_pe, a_hs, a_vs, a_vid, a_ls, a_fs;
    logic [3:0] a_h, a_v;
    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_POL(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .pix_en(a_pe), .h_count(a_h), .v_count(a_v),
        .h_sync(a_hs), .v_sync(a_vs), .video_on(a_vid),
        .line_start(a_ls), .frame_start(a_fs));

    // Instance b: default timing, CLK_DIV=1
    logic       b_pe, b_hs, b_vs, b_vid, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    vga_timing_gen #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .pix_en(b_pe), .h_count(b_h), .v_count(b_v),
        .h_sync(b_hs), .v_sync(b_vs), .video_on(b_vid),
        .line_start(b_ls), .frame_start(b_fs));

    // Instance c: all defaults (CLK_DIV=4)
    logic       c_pe, c_hs, c_vs, c_vid, c_ls, c_fs;
    logic [9:0] c_h, c_v;
    vga_timing_gen dut_c (
        .clk(clk), .rst(rst), .pix_en(c_pe), .h_count(c_h), .v_count(c_v),
        .h_sync(c_hs), .v_sync(c_vs), .video_on(c_vid),
        .line_start(c_ls), .frame_start(c_fs));

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d: got %0d, expected %0d", tag, n_edge, obs, exp);
        end
    endtask

    // Pixel time model: after edge n (n>=1) the divider has produced floor((n-1)/d)
    // completed pixel advances; pix_en is high after every d-th edge.
    function automatic void ref_model(input int n, input bit r, input int d,
                                      input int ha, input int hf, input int hs, input int hb,
                                      input int va, input int vf, input int vs, input int vb,
                                      input bit pol,
                                      output int h, output int v,
                                      output bit pe, output bit hsy, output bit vsy,
                                      output bit vid, output bit ls, output bit fs);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int p;
        bit adv;
        if (r) begin
            h = 0; v = 0; pe = 0; hsy = ~pol; vsy = ~pol; vid = 0; ls = 0; fs = 0;
            return;
        end
        p   = ((n - 1) / d) % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        pe  = (n % d) == 0;
        adv = (n > 1) && (((n - 1) % d) == 0);
        vid = (h < ha) && (v < va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        ls  = adv && (h == 0);
        fs  = ls && (v == 0);
    endfunction

    task automatic check_dut(input string nm, input int d,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input bit pol,
                             input int h_o, input int v_o, input bit pe_o,
                             input bit hs_o, input bit vs_o, input bit vid_o,
                             input bit ls_o, input bit fs_o);
        int h, v;
        bit pe, hsy, vsy, vid, ls, fs;
        ref_model(n_edge, in_rst, d, ha, hf, hs, hb, va, vf, vs, vb, pol,
                  h, v, pe, hsy, vsy, vid, ls, fs);
        check({nm, ".h_count"},     h_o,   h);
        check({nm, ".v_count"},     v_o,   v);
        check({nm, ".pix_en"},      pe_o,  pe);
        check({nm, ".h_sync"},      hs_o,  hsy);
        check({nm, ".v_sync"},      vs_o,  vsy);
        check({nm, ".video_on"},    vid_o, vid);
        check({nm, ".line_start"},  ls_o,  ls);
        check({nm, ".frame_start"}, fs_o,  fs);
    endtask

    initial begin
        int rst_left = 2;
        for (int cyc = 0; cyc < 40000 && n_bad < 50; cyc++) begin
            @(negedge clk);
            if (rst) begin
                n_edge = 0;
                in_rst = 1'b1;
            end else begin
                n_edge++;
                in_rst = 1'b0;
            end
            check_dut("a", 3, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1,
                      int'(a_h), int'(a_v), a_pe, a_hs, a_vs, a_vid, a_ls, a_fs);
            check_dut("b", 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                      int'(b_h), int'(b_v), b_pe, b_hs, b_vs, b_vid, b_ls, b_fs);
            check_dut("c", 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                      int'(c_h), int'(c_v), c_pe, c_hs, c_vs, c_vid, c_ls, c_fs);

            // Directed 3-clk mid-frame reset plus rare random resets of 1-3 clks
            if (cyc == 25000)
                rst_left = 3;
            else if (rst_left == 0 && cyc > 100 && $urandom_range(0, 4999) == 0)
                rst_left = $urandom_range(1, 3);
            if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else begin
                rst = 1'b0;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
